// File: rtl/lease_req_pkg.sv
// Shared definitions for the Lease Cache request-FIFO reader: FSM encoding,
// default widths and request-word field helpers.
package lease_req_pkg;

  // Reader control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Default geometry of the request path.
  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_BUF_DEPTH = 3;
  localparam int unsigned DEF_CNT_W     = 16;

  // A request word is {rw, addr}; the rw flag sits just above the address.
  function automatic int unsigned rw_bit(input int unsigned addr_w);
    return addr_w;
  endfunction

  // Number of bits needed to hold an occupancy count of 0..depth.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage : lease_req_pkg

// File: rtl/req_buf.sv
// Small in-order request buffer. Any depth is supported: pointers wrap
// explicitly at DEPTH-1 rather than relying on power-of-2 rollover.
module req_buf
  import lease_req_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned W     = DEF_ADDR_W + 1,
  localparam int unsigned CW   = count_width(DEPTH),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  // Advance a pointer, wrapping at the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // NOTE: blocking '=' here because this is combinational; the flops below
    // use '<=' so every register samples pre-edge values.
    do_pop   = pop_i & (count_q != '0);
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CW'(push_i) - CW'(do_pop);
  end

  // Buffer registers; synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      // NOTE: the storage is reset too (it is only a few entries) so the
      // registered head reads as zero straight out of reset.
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry and status come straight from registers.
  always_comb begin
    head_o  = mem_q[rd_ptr_q];
    count_o = count_q;
    empty_o = (count_q == '0);
  end

endmodule : req_buf

// File: rtl/fifo_req_reader.sv
// Read-side consumer for the request FIFO: pops words with one-cycle read
// latency, buffers them and presents a valid/ready request stream.
module fifo_req_reader
  import lease_req_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic              fifo_empty_i,
  input  logic [ADDR_W:0]   fifo_dout_i,
  output logic              fifo_rd_en_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_rw_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [CNT_W-1:0]  req_count_o,
  output logic              idle_o
);

  localparam int unsigned W      = ADDR_W + 1;
  localparam int unsigned CW     = count_width(BUF_DEPTH);
  localparam int unsigned RW_BIT = rw_bit(ADDR_W);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

  state_e           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [W-1:0]     head;
  logic [CW-1:0]    buf_count;
  logic             buf_empty;
  logic             credit_ok;
  logic             pending;
  logic             transfer;
  logic             rd_en;

  // Local buffer: pushed by the word returning from the FIFO, popped on handshake.
  req_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (W)
  ) u_req_buf (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout_i),
    .pop_i       (transfer),
    .head_o      (head),
    .count_o     (buf_count),
    .empty_o     (buf_empty)
  );

  // Credit check, pop strobe, handshake and next-state decisions.
  always_comb begin
    // A slot is reserved for every read in flight; a same-cycle pop is not
    // credited, which keeps the check independent of req_ready_i.
    credit_ok  = ({1'b0, buf_count} + (CW + 1)'(inflight_q)) < DEPTH_C;
    rd_en      = (state_q == ST_RUN) & enable_i & ~fifo_empty_i & credit_ok;
    pending    = ~buf_empty | inflight_q;
    transfer   = ~buf_empty & req_ready_i;
    inflight_d = rd_en;
    count_d    = transfer ? count_q + CNT_W'(1) : count_q;

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_i) state_d = pending ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (enable_i)      state_d = ST_RUN;
        else if (!pending) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, in-flight flag and issued-request counter.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  // Output mapping: the request fields are the registered buffer head.
  always_comb begin
    fifo_rd_en_o = rd_en;
    req_valid_o  = ~buf_empty;
    req_rw_o     = head[RW_BIT];
    req_addr_o   = head[ADDR_W-1:0];
    req_count_o  = count_q;
    idle_o       = buf_empty & ~inflight_q;
  end

endmodule : fifo_req_reader
